keycode_action_ctrl: RTL

Parametrised successor to the combinational keycode decoder. It scans `NUM_SLOTS` USB keycode bytes and turns W/S/A/D/P/R/Enter into registered single-cycle action pulses. Down/left/right auto-repeat in the Tetris style: a DAS delay, then a fixed ARR rate, both counted in frame ticks. Pause/resume is a sticky `paused` level. The block sits between the USB keycode register and the game-logic FSM, which consumes pulses, never raw levels.

---
 rtl/keycode_action_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/keycode_action_ctrl.sv
// Scans USB keycode slots and turns W/S/A/D/P/R/Enter into registered action pulses,
// with DAS/ARR auto-repeat for down/left/right and a sticky pause level.
module keycode_action_ctrl #(
    parameter int NUM_SLOTS  = 2,
    parameter int DAS_DELAY  = 16,
    parameter int ARR_PERIOD = 6
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [8*NUM_SLOTS-1:0] keycode,
    input  logic                   tick,
    output logic                   up_p,
    output logic                   down_p,
    output logic                   left_p,
    output logic                   right_p,
    output logic                   pause_p,
    output logic                   resume_p,
    output logic                   enter_p,
    output logic                   paused,
    output logic [6:0]             held,
    output logic [5:0]             dbg_rpt_state
);
    localparam int MAX_CNT = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bit order everywhere: {enter, resume, pause, right, left, down, up}
    logic [6:0] held_now;
    logic [6:0] held_q;
    logic [6:0] press;
    logic [6:0] pulse_q, pulse_d;
    logic       paused_q, paused_d;
    logic       gate;
    logic       lr_conflict;

    // Repeat FSM index 0/1/2 maps to down/left/right (held bits 1/2/3)
    rpt_state_e    state_q [3];
    rpt_state_e    state_d [3];
    logic [CW-1:0] cnt_q   [3];
    logic [CW-1:0] cnt_d   [3];
    logic [2:0]    rpt;

    always_comb begin
        held_now = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            case (keycode[8*i +: 8])
                8'h1A:   held_now[0] = 1'b1;
                8'h16:   held_now[1] = 1'b1;
                8'h04:   held_now[2] = 1'b1;
                8'h07:   held_now[3] = 1'b1;
                8'h13:   held_now[4] = 1'b1;
                8'h15:   held_now[5] = 1'b1;
                8'h28:   held_now[6] = 1'b1;
                default: ;
            endcase
        end
    end

    assign press       = held_now & ~held_q;
    // The pause edge itself already suppresses movement
    assign gate        = paused_q | press[4];
    assign lr_conflict = held_now[2] & held_now[3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            rpt[k]     = 1'b0;
            if (gate || !held_now[k+1]) begin
                state_d[k] = RPT_IDLE;
                cnt_d[k]   = '0;
            end else if (k != 0 && lr_conflict) begin
                state_d[k] = RPT_DELAY;
                cnt_d[k]   = '0;
            end else begin
                case (state_q[k])
                    RPT_IDLE: begin
                        if (press[k+1]) begin
                            state_d[k] = RPT_DELAY;
                            cnt_d[k]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (tick) begin
                            if (cnt_q[k] == DAS_LAST) begin
                                rpt[k]     = 1'b1;
                                state_d[k] = RPT_REPEAT;
                                cnt_d[k]   = '0;
                            end else begin
                                cnt_d[k] = cnt_q[k] + CW'(1);
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (tick) begin
                            if (cnt_q[k] == ARR_LAST) begin
                                rpt[k]   = 1'b1;
                                cnt_d[k] = '0;
                            end else begin
                                cnt_d[k] = cnt_q[k] + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[k] = RPT_IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pulse_d[0]   = press[0] & ~gate;
        pulse_d[3:1] = (press[3:1] | rpt) & {3{~gate}};
        pulse_d[6:4] = press[6:4];
        // Pause wins over a coincident resume edge
        if (press[4]) begin
            paused_d = 1'b1;
        end else if (press[5]) begin
            paused_d = 1'b0;
        end else begin
            paused_d = paused_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            held_q   <= '0;
            pulse_q  <= '0;
            paused_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= RPT_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            held_q   <= held_now;
            pulse_q  <= pulse_d;
            paused_q <= paused_d;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign up_p          = pulse_q[0];
    assign down_p        = pulse_q[1];
    assign left_p        = pulse_q[2];
    assign right_p       = pulse_q[3];
    assign pause_p       = pulse_q[4];
    assign resume_p      = pulse_q[5];
    assign enter_p       = pulse_q[6];
    assign paused        = paused_q;
    assign held          = held_q;
    assign dbg_rpt_state = {state_q[2], state_q[1], state_q[0]};

endmodule
